// File: rtl/seq_divmod_pkg.sv
// -----------------------------------------------------------------------------
// seq_divmod_pkg
// Shared types for the sequential divider/remainder unit.
//   state_e : FSM state encoding (2 bits) used by seq_divmod.
// -----------------------------------------------------------------------------
package seq_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divmod_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Most-significant-set-bit encoder.
// Ports:
//   in_i  [WIDTH-1:0]     : value to scan
//   msb_o [WIDTH_LOG:0]   : {found, position}; the low WIDTH_LOG bits hold the
//                           index of the highest set bit, the top bit is 1 when
//                           any bit of in_i is set (position is 0 otherwise).
// -----------------------------------------------------------------------------
module prio_enc #(
  parameter int WIDTH_LOG = 4
) (
  input  logic [(1 << WIDTH_LOG)-1:0] in_i,
  output logic [WIDTH_LOG:0]          msb_o
);

  localparam int WIDTH = 1 << WIDTH_LOG;

  logic [WIDTH_LOG-1:0] pos;
  logic                 found;

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        pos   = WIDTH_LOG'(i);
        found = 1'b1;
      end
    end
  end

  assign msb_o = {found, pos};

endmodule

// File: rtl/seq_divmod.sv
// -----------------------------------------------------------------------------
// seq_divmod
// Sequential unsigned divider/remainder. The divisor is aligned to the dividend
// in one step from the MSB-position difference, then one restoring
// shift-subtract iteration runs per cycle. One operation in flight.
//
// Optional build macro: SEQ_DIVMOD_EARLY_EXIT_EN
//   defined   : SUB leaves for DONE as soon as the remainder becomes 0.
//   undefined : SUB always runs exactly shift+1 iterations.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  unit idle, can accept (state == IDLE)
//   a          in   dividend  [WIDTH-1:0]
//   b          in   divisor   [WIDTH-1:0]
//   out_valid  out  result valid, held until accepted
//   out_ready  in   consumer accepts result
//   quo        out  quotient  [WIDTH-1:0]
//   rem        out  remainder [WIDTH-1:0]
//   div_zero   out  b was 0 for this result
// -----------------------------------------------------------------------------
module seq_divmod
  import seq_divmod_pkg::*;
#(
  parameter int WIDTH_LOG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1 << WIDTH_LOG)-1:0] a,
  input  logic [(1 << WIDTH_LOG)-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(1 << WIDTH_LOG)-1:0] quo,
  output logic [(1 << WIDTH_LOG)-1:0] rem,
  output logic                        div_zero
);

  localparam int WIDTH = 1 << WIDTH_LOG;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH_LOG-1:0] cnt_q, cnt_d;
  logic                 dz_q, dz_d;
  logic                 ov_q, ov_d;

  logic [WIDTH_LOG:0]   ma_full, mb_full;
  logic [WIDTH_LOG-1:0] ma, mb, shift;
  logic                 rem_nz, d_nz;
  logic                 ge;
  logic [WIDTH-1:0]     rem_sub, rem_nxt;

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_a (.in_i(rem_q), .msb_o(ma_full));
  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_b (.in_i(d_q),   .msb_o(mb_full));

  // The encoder's found flag doubles as the zero test for each operand.
  assign ma     = ma_full[WIDTH_LOG-1:0];
  assign mb     = mb_full[WIDTH_LOG-1:0];
  assign rem_nz = ma_full[WIDTH_LOG];
  assign d_nz   = mb_full[WIDTH_LOG];
  assign shift  = ma - mb;

  // Restoring step: d is pre-aligned, so a plain WIDTH-bit compare suffices.
  assign ge      = (rem_q >= d_q);
  assign rem_sub = rem_q - d_q;
  assign rem_nxt = ge ? rem_sub : rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    d_d     = d_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    ov_d    = ov_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = a;
          d_d     = b;
          quo_d   = '0;
          dz_d    = 1'b0;
          cnt_d   = '0;
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        if (!d_nz) begin
          dz_d    = 1'b1;
          quo_d   = '1;
          state_d = DONE;
        end else if (!rem_nz || (ma < mb)) begin
          quo_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = shift;
          d_d     = d_q << shift;
          state_d = SUB;
        end
      end

      SUB: begin
        rem_d = rem_nxt;
        if (ge) begin
          quo_d[cnt_q] = 1'b1;
        end
        d_d = d_q >> 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`ifdef SEQ_DIVMOD_EARLY_EXIT_EN
        // Untouched low quotient bits are already 0, so stopping here is exact.
        if (rem_nxt == '0) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        // out_valid rises one cycle after DONE entry; out_ready seen before
        // that is ignored because the handshake is gated by ov_q.
        ov_d = 1'b1;
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign div_zero  = dz_q;

  // Alignment guarantees a nonzero divisor for every iteration, and the
  // iteration with cnt==0 is always the last one.
  a_sub_d_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (state_q == SUB) |-> (d_q != '0));
  a_sub_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    ((state_q == SUB) && (cnt_q == '0)) |=> (state_q != SUB));

endmodule

// File: tb/tb_seq_divmod.sv
module tb_seq_divmod;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quo;
  logic [15:0] rem;
  logic        div_zero;

  int checks;
  int failures;

  seq_divmod #(.WIDTH_LOG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure accept-to-out_valid latency, check the
  // result, optionally hold it under back-pressure, then retire it.
  task automatic run_op(input string tag,
                        input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input int elat,
                        input int hold, input logic early_ready);
    int lat;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = early_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_quo"}, 32'(quo), 32'(eq));
    chk({tag, "_rem"}, 32'(rem), 32'(er));
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_quo"}, 32'(quo), 32'(eq));
      chk({tag, "_hold_rem"}, 32'(rem), 32'(er));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_retired_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_retired_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat_64_8;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SEQ_DIVMOD_EARLY_EXIT_EN
    lat_64_8 = 3;
`else
    lat_64_8 = 6;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quo", 32'(quo), 32'd0);
    chk("reset_rem", 32'(rem), 32'd0);
    chk("reset_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 100/7: shift 4, held 5 cycles under back-pressure.
    run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 7, 5, 1'b0);
    // Divisor larger than dividend; out_ready raised early has no effect.
    run_op("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 2, 0, 1'b1);
    run_op("d1234_0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 2, 0, 1'b0);
    run_op("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 2, 0, 1'b0);
    run_op("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 18, 0, 1'b0);
    run_op("d64_8", 16'd64, 16'd8, 16'd8, 16'd0, 1'b0, lat_64_8, 0, 1'b0);
    run_op("d77_77", 16'd77, 16'd77, 16'd1, 16'd0, 1'b0, 3, 0, 1'b0);
    run_op("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 7, 0, 1'b0);

    // Reset in the middle of a long SUB sequence.
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quo", 32'(quo), 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    chk("abort_div_zero", 32'(div_zero), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("after_abort_out_valid", 32'(out_valid), 32'd0);
    run_op("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 5, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
